keypad_ctrl: RTL and testbench

Sequencing controller for the 4x4 keypad scanner.
- Takes the scanner's frozen key code and row-hit flag, and drives the scanner's stopscan input.
- Debounces both press and release, and decodes the one-hot {col,row} code to a hex digit.
- Keeps a two-digit history (newest and previous) for the dual seven-segment display path.
- Sits between keyscanner and the display multiplexer; one accepted key per physical press.

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/keypad_ctrl_keycode_decode.sv | 25 ++
 rtl/keypad_ctrl.sv | 138 +++++++++++++
 tb/tb_keypad_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the keypad sequencing controller:
//   kp_state_t      - controller FSM states
//   KEYMAP          - 4x4 hex keymap indexed [row][col]
//   onehot4_to_idx  - one-hot nibble to {valid, idx[1:0]}
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} kp_state_t;

  // Physical key legend, row-major: KEYMAP[row][col]
  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Returns {valid, idx}; valid only when exactly one bit is set.
  function automatic logic [2:0] onehot4_to_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 3'b1_00;
      4'b0010: return 3'b1_01;
      4'b0100: return 3'b1_10;
      4'b1000: return 3'b1_11;
      default: return 3'b0_00;
    endcase
  endfunction

endpackage

// File: rtl/keypad_ctrl_keycode_decode.sv
// keycode_decode
// Combinational decode of the scanner's {col[3:0], row[3:0]} code to a hex
// digit using the package keymap.
//   scan_code - {col, row}, each nibble one-hot for a single valid key
//   dec_valid - 1 when both nibbles are exactly one-hot
//   dec_digit - keymap value (0 when the code is invalid)
module keycode_decode
  import keypad_pkg::*;
(
  input  logic [7:0] scan_code,
  output logic       dec_valid,
  output logic [3:0] dec_digit
);

  logic [2:0] row_idx;
  logic [2:0] col_idx;

  always_comb begin
    row_idx   = onehot4_to_idx(scan_code[3:0]);
    col_idx   = onehot4_to_idx(scan_code[7:4]);
    dec_valid = row_idx[2] & col_idx[2];
    dec_digit = dec_valid ? KEYMAP[row_idx[1:0]][col_idx[1:0]] : 4'h0;
  end

endmodule

// File: rtl/keypad_ctrl.sv
// keypad_ctrl
// Sequencing controller between the 4x4 keyscanner and the display mux.
// Freezes the scanner while a key is down, debounces press and release,
// and keeps a two-digit history of accepted keys.
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   rowpressed - scanner: some row high on the driven column
//   scan_code  - scanner: frozen {col, row} one-hot code
//   stopscan   - to scanner: hold column rotation (1 in every non-IDLE state)
//   digit_new  - newest accepted key value
//   digit_old  - key value accepted before digit_new
//   key_valid  - one-cycle pulse per accepted key
//   key_held   - 1 in HELD / DB_RELEASE
module keypad_ctrl
  import keypad_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 50000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rowpressed,
  input  logic [7:0] scan_code,
  output logic       stopscan,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  kp_state_t        state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             stopscan_q,  stopscan_d;
  logic [3:0]       digit_new_q, digit_new_d;
  logic [3:0]       digit_old_q, digit_old_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q,  key_held_d;

  logic             dec_valid;
  logic [3:0]       dec_digit;

  keycode_decode u_decode (
    .scan_code (scan_code),
    .dec_valid (dec_valid),
    .dec_digit (dec_digit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stopscan_q  <= 1'b0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stopscan_q  <= stopscan_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    key_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rowpressed) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!rowpressed) begin
          // Press bounce: drop it silently.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          // Multi-key or empty codes still lock into HELD so the press
          // is consumed, but they never reach the digit history.
          if (dec_valid) begin
            digit_old_d = digit_new_q;
            digit_new_d = dec_digit;
            key_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!rowpressed) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_RELEASE: begin
        if (rowpressed) begin
          // Release bounce: key is still considered down.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Status outputs are registered copies of the next state.
    stopscan_d = (state_d != IDLE);
    key_held_d = (state_d == HELD) || (state_d == DB_RELEASE);
  end

  assign stopscan  = stopscan_q;
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_ctrl.sv
// tb_keypad_ctrl
// Directed bench for keypad_ctrl with DEBOUNCE_CYCLES=4 and a 10 ns clock.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_keypad_ctrl;

  logic       clk;
  logic       reset;
  logic       rowpressed;
  logic [7:0] scan_code;
  logic       stopscan;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_valid;
  logic       key_held;

  int errors   = 0;
  int checks   = 0;
  int kv_count = 0;
  int kv_base  = 0;

  keypad_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rowpressed (rowpressed),
    .scan_code  (scan_code),
    .stopscan   (stopscan),
    .digit_new  (digit_new),
    .digit_old  (digit_old),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // key_valid pulses counted mid-cycle
  always @(negedge clk) if (key_valid === 1'b1) kv_count++;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset      = 1'b0;
    rowpressed = 1'b0;
    scan_code  = 8'h00;

    // 1. reset, then idle with no key
    step(3);
    chk("rst_stopscan", int'(stopscan), 0);
    chk("rst_digit_new", int'(digit_new), 0);
    chk("rst_digit_old", int'(digit_old), 0);
    chk("rst_key_valid", int'(key_valid), 0);
    chk("rst_key_held", int'(key_held), 0);
    reset = 1'b1;
    step(3);
    chk("idle_stopscan", int'(stopscan), 0);
    chk("idle_kv_count", kv_count, 0);

    // 2. key 6 (col2,row1) held 10 cycles
    scan_code  = 8'h42;
    rowpressed = 1'b1;
    step(1);                               // E0
    chk("k6_stopscan_e0", int'(stopscan), 1);
    chk("k6_kv_e0", int'(key_valid), 0);
    step(3);                               // E3
    chk("k6_kv_e3", int'(key_valid), 0);
    step(1);                               // E4
    chk("k6_kv_e4", int'(key_valid), 1);
    chk("k6_digit_new", int'(digit_new), 6);
    chk("k6_digit_old", int'(digit_old), 0);
    chk("k6_key_held", int'(key_held), 1);
    step(1);
    chk("k6_kv_drop", int'(key_valid), 0);
    step(4);
    chk("k6_kv_count", kv_count, 1);
    rowpressed = 1'b0;
    step(5);
    chk("k6_rel_stopscan", int'(stopscan), 0);
    chk("k6_rel_key_held", int'(key_held), 0);

    // 3. key C (col3,row2)
    kv_base    = kv_count;
    scan_code  = 8'h84;
    rowpressed = 1'b1;
    step(5);
    chk("kc_kv", int'(key_valid), 1);
    chk("kc_digit_new", int'(digit_new), 'hC);
    chk("kc_digit_old", int'(digit_old), 6);
    step(3);
    rowpressed = 1'b0;
    step(5);
    chk("kc_kv_count", kv_count - kv_base, 1);
    chk("kc_rel_stopscan", int'(stopscan), 0);

    // 4. press bounce: 1,1,0,1,1,0...
    kv_base    = kv_count;
    rowpressed = 1'b1;
    step(2);
    chk("bnc_stopscan_hi", int'(stopscan), 1);
    rowpressed = 1'b0;
    step(1);
    chk("bnc_stopscan_lo", int'(stopscan), 0);
    rowpressed = 1'b1;
    step(2);
    rowpressed = 1'b0;
    step(3);
    chk("bnc_kv_count", kv_count - kv_base, 0);
    chk("bnc_digit_new", int'(digit_new), 'hC);
    chk("bnc_digit_old", int'(digit_old), 6);
    chk("bnc_stopscan_end", int'(stopscan), 0);

    // 5. key 5 (col1,row1) with release bounce
    kv_base    = kv_count;
    scan_code  = 8'h22;
    rowpressed = 1'b1;
    step(5);
    chk("k5_kv", int'(key_valid), 1);
    chk("k5_digit_new", int'(digit_new), 5);
    chk("k5_digit_old", int'(digit_old), 'hC);
    step(2);
    rowpressed = 1'b0;
    step(2);
    chk("rb_held_lo2", int'(key_held), 1);
    rowpressed = 1'b1;
    step(1);
    chk("rb_held_back", int'(key_held), 1);
    rowpressed = 1'b0;
    step(4);
    chk("rb_held_lo4", int'(key_held), 1);
    chk("rb_stopscan_lo4", int'(stopscan), 1);
    step(1);
    chk("rb_held_lo5", int'(key_held), 0);
    chk("rb_stopscan_lo5", int'(stopscan), 0);
    chk("rb_kv_count", kv_count - kv_base, 1);

    // same digit again shifts history
    rowpressed = 1'b1;
    step(5);
    chk("k55_kv", int'(key_valid), 1);
    chk("k55_digit_new", int'(digit_new), 5);
    chk("k55_digit_old", int'(digit_old), 5);
    rowpressed = 1'b0;
    step(5);

    // 6. invalid code (row nibble has two bits set)
    kv_base    = kv_count;
    scan_code  = 8'h46;
    rowpressed = 1'b1;
    step(5);
    chk("inv_key_held", int'(key_held), 1);
    chk("inv_stopscan", int'(stopscan), 1);
    step(5);
    chk("inv_kv_count", kv_count - kv_base, 0);
    chk("inv_digit_new", int'(digit_new), 5);
    chk("inv_digit_old", int'(digit_old), 5);
    rowpressed = 1'b0;
    step(5);
    chk("inv_rel_held", int'(key_held), 0);

    // async reset in DB_PRESS, then key 1 (col0,row0) still held
    scan_code  = 8'h11;
    rowpressed = 1'b1;
    step(2);
    chk("ar_stopscan_pre", int'(stopscan), 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_stopscan", int'(stopscan), 0);
    chk("ar_digit_new", int'(digit_new), 0);
    chk("ar_digit_old", int'(digit_old), 0);
    chk("ar_key_held", int'(key_held), 0);
    chk("ar_key_valid", int'(key_valid), 0);
    step(1);
    reset   = 1'b1;
    kv_base = kv_count;
    step(5);
    chk("ar_k1_kv", int'(key_valid), 1);
    chk("ar_k1_digit_new", int'(digit_new), 1);
    chk("ar_k1_digit_old", int'(digit_old), 0);
    step(5);
    chk("ar_k1_kv_count", kv_count - kv_base, 1);
    rowpressed = 1'b0;
    step(5);
    chk("ar_rel_stopscan", int'(stopscan), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
